// File: rtl/byte_pack_pkg.sv
// Shared definitions for the byte-to-word packer.
//   DEF_BYTE_W / DEF_LANES / DEF_CNT_W : default parameter values
//   lane_idx_t : lane counter type for the default lane count
//   be_t       : per-lane byte-enable vector for the default lane count
//   lane_lo()  : low bit index of the lane that holds byte k. The
//                extractor bench uses it to locate bytes inside a word.
package byte_pack_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int DEF_CNT_W  = 16;

  typedef logic [$clog2(DEF_LANES)-1:0] lane_idx_t;
  typedef logic [DEF_LANES-1:0]         be_t;

  // Byte k sits in lane k (LSB-first) or in the mirrored lane (MSB-first).
  function automatic int unsigned lane_lo(input int unsigned k, input bit msb_first);
    if (msb_first) begin
      return (int'(DEF_LANES) - 1 - k) * DEF_BYTE_W;
    end
    return k * DEF_BYTE_W;
  endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Single-entry valid/ready register slice for packed words.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   load_i          : capture word_i/be_i/last_i on this edge
//                     (only asserted while out_free_o is high)
//   word_i, be_i, last_i : word to capture
//   out_ready_i     : consumer accepts the held word
//   out_valid_o, out_word_o, out_be_o, out_last_o : registered output
//   out_free_o      : slice can take a new word this cycle
//                     (empty, or its current word drains on this edge)
module pack_out_reg
  import byte_pack_pkg::*;
#(
  parameter int WORD_W = DEF_LANES * DEF_BYTE_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [LANES-1:0]  be_i,
  input  logic              last_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_word_o,
  output logic [LANES-1:0]  out_be_o,
  output logic              out_last_o,
  output logic              out_free_o
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [LANES-1:0]  be_q, be_d;
  logic              last_q, last_d;

  assign out_free_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    be_d    = be_q;
    last_d  = last_q;
    if (load_i) begin
      // A load may coincide with the drain of the previous word.
      valid_d = 1'b1;
      word_d  = word_i;
      be_d    = be_i;
      last_d  = last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      be_q    <= be_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_word_o  = word_q;
  assign out_be_o    = be_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/byte_word_packer.sv
// Packs a stream of bytes into LANES-byte words with byte enables and a
// packet-last flag.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : input byte handshake
//   in_byte, in_last        : byte and end-of-packet marker
//   out_valid/out_ready     : output word handshake
//   out_word, out_be        : packed word, lane enables (bit k = byte k)
//   out_last                : word carries the last byte of a packet
//   words_sent              : wrapping count of output handshakes
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is a pure register (low only while a completed word
// waits for the output slice) and never depends on in_valid or in_byte.
// out_valid/out_word/out_be/out_last are registered and hold their values
// while out_valid && !out_ready.
module byte_word_packer
  import byte_pack_pkg::*;
#(
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter int LANES     = DEF_LANES,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W-1:0]       in_byte,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BYTE_W-1:0] out_word,
  output logic [LANES-1:0]        out_be,
  output logic                    out_last,
  output logic [CNT_W-1:0]        words_sent
);

  localparam int WORD_W = LANES * BYTE_W;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [IDX_W-1:0] cnt_t;

  localparam cnt_t             LAST_IDX = cnt_t'(LANES - 1);
  localparam cnt_t             CNT_ONE  = cnt_t'(1);
  localparam logic [CNT_W-1:0] WS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Accumulator state. While acc_pend_q is set the accumulator holds a
  // finished word that the output slice could not take yet.
  cnt_t              cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]  acc_be_q, acc_be_d;
  logic              acc_last_q, acc_last_d;
  logic              acc_pend_q, acc_pend_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic              accept;
  logic              complete;
  logic              out_free;
  logic [WORD_W-1:0] merged_word;
  logic [LANES-1:0]  merged_be;

  logic              load;
  logic [WORD_W-1:0] load_word;
  logic [LANES-1:0]  load_be;
  logic              load_last;

  assign in_ready = !acc_pend_q;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((cnt_q == LAST_IDX) || in_last);

  // Accumulator contents with the incoming byte dropped into lane cnt_q.
  always_comb begin
    merged_word = acc_q;
    merged_be   = acc_be_q;
    for (int k = 0; k < LANES; k++) begin
      if (cnt_q == cnt_t'(k)) begin
        merged_be[k] = 1'b1;
        if (MSB_FIRST) begin
          merged_word[(LANES-k)*BYTE_W-1 -: BYTE_W] = in_byte;
        end else begin
          merged_word[k*BYTE_W +: BYTE_W] = in_byte;
        end
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_be_d   = acc_be_q;
    acc_last_d = acc_last_q;
    acc_pend_d = acc_pend_q;
    load       = 1'b0;
    load_word  = merged_word;
    load_be    = merged_be;
    load_last  = in_last;

    if (acc_pend_q) begin
      // A parked word leaves as soon as the slice frees up.
      load_word = acc_q;
      load_be   = acc_be_q;
      load_last = acc_last_q;
      if (out_free) begin
        load       = 1'b1;
        acc_pend_d = 1'b0;
        acc_d      = '0;
        acc_be_d   = '0;
        acc_last_d = 1'b0;
      end
    end else if (accept) begin
      if (complete) begin
        cnt_d = '0;
        if (out_free) begin
          load       = 1'b1;
          acc_d      = '0;
          acc_be_d   = '0;
          acc_last_d = 1'b0;
        end else begin
          acc_d      = merged_word;
          acc_be_d   = merged_be;
          acc_last_d = in_last;
          acc_pend_d = 1'b1;
        end
      end else begin
        cnt_d    = cnt_q + CNT_ONE;
        acc_d    = merged_word;
        acc_be_d = merged_be;
      end
    end
  end

  always_comb begin
    words_d = words_q;
    if (out_valid && out_ready) begin
      words_d = words_q + WS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_be_q   <= '0;
      acc_last_q <= 1'b0;
      acc_pend_q <= 1'b0;
      words_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_be_q   <= acc_be_d;
      acc_last_q <= acc_last_d;
      acc_pend_q <= acc_pend_d;
      words_q    <= words_d;
    end
  end

  pack_out_reg #(
    .WORD_W (WORD_W),
    .LANES  (LANES)
  ) u_out_reg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .word_i      (load_word),
    .be_i        (load_be),
    .last_i      (load_last),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_word_o  (out_word),
    .out_be_o    (out_be),
    .out_last_o  (out_last),
    .out_free_o  (out_free)
  );

  assign words_sent = words_q;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

  localparam int N_RAND   = 10000;
  localparam int BUDGET   = 60000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_last;
  logic       out_ready;

  // LSB-first instance outputs
  logic        l_in_ready, l_out_valid, l_out_last;
  logic [31:0] l_out_word;
  logic [3:0]  l_out_be;
  logic [15:0] l_words_sent;

  // MSB-first instance outputs
  logic        m_in_ready, m_out_valid, m_out_last;
  logic [31:0] m_out_word;
  logic [3:0]  m_out_be;
  logic [15:0] m_words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  byte_word_packer #(.BYTE_W(8), .LANES(4), .MSB_FIRST(1'b0), .CNT_W(16)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_byte(in_byte), .in_last(in_last),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_word(l_out_word),
    .out_be(l_out_be), .out_last(l_out_last), .words_sent(l_words_sent)
  );

  byte_word_packer #(.BYTE_W(8), .LANES(4), .MSB_FIRST(1'b1), .CNT_W(16)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_byte(in_byte), .in_last(in_last),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_word(m_out_word),
    .out_be(m_out_be), .out_last(m_out_last), .words_sent(m_words_sent)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Offers one byte for one clock; all bytes here go in while in_ready=1.
  task automatic drive_byte(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_out_last, l_words_sent, l_in_ready} !==
        {1'b0, 32'h0, 4'h0, 1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_lsb: valid=%b word=%h be=%h last=%b ws=%0d rdy=%b, want 0/0/0/0/0/1",
               l_out_valid, l_out_word, l_out_be, l_out_last, l_words_sent, l_in_ready);
    end
    n_checks++;
    if ({m_out_valid, m_out_word, m_out_be, m_out_last, m_words_sent, m_in_ready} !==
        {1'b0, 32'h0, 4'h0, 1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_msb: valid=%b word=%h be=%h last=%b ws=%0d rdy=%b, want 0/0/0/0/0/1",
               m_out_valid, m_out_word, m_out_be, m_out_last, m_words_sent, m_in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lsb_first();
    apply_reset();
    out_ready = 1'b1;
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b0);
    n_checks++;
    if (l_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_early_valid: out_valid=%b after 3 bytes, want 0", l_out_valid);
    end
    drive_byte(8'h44, 1'b0);
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_out_last} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL lsb_word: valid=%b word=%h be=%h last=%b, want 1 44332211 f 0",
               l_out_valid, l_out_word, l_out_be, l_out_last);
    end
    step();
    n_checks++;
    if ({l_out_valid, l_words_sent} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL lsb_drain: valid=%b words_sent=%0d, want 0 1", l_out_valid, l_words_sent);
    end
  endtask

  task automatic test_msb_first();
    apply_reset();
    out_ready = 1'b1;
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b0);
    drive_byte(8'h44, 1'b0);
    n_checks++;
    if ({m_out_valid, m_out_word, m_out_be, m_out_last} !== {1'b1, 32'h11223344, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL msb_word: valid=%b word=%h be=%h last=%b, want 1 11223344 f 0",
               m_out_valid, m_out_word, m_out_be, m_out_last);
    end
    step();
  endtask

  task automatic test_partial_last();
    apply_reset();
    out_ready = 1'b1;
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b1);
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_out_last} !== {1'b1, 32'h0000BBAA, 4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL partial_lsb: valid=%b word=%h be=%h last=%b, want 1 0000bbaa 3 1",
               l_out_valid, l_out_word, l_out_be, l_out_last);
    end
    n_checks++;
    if ({m_out_word, m_out_be, m_out_last} !== {32'hAABB0000, 4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL partial_msb: word=%h be=%h last=%b, want aabb0000 3 1",
               m_out_word, m_out_be, m_out_last);
    end
    // next packet follows immediately and must start at lane 0
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h03, 1'b0);
    drive_byte(8'h04, 1'b0);
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_out_last, l_words_sent} !==
        {1'b1, 32'h04030201, 4'hF, 1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL next_packet: valid=%b word=%h be=%h last=%b ws=%0d, want 1 04030201 f 0 1",
               l_out_valid, l_out_word, l_out_be, l_out_last, l_words_sent);
    end
    step();
  endtask

  task automatic test_back_pressure();
    logic [31:0] w1;
    logic [31:0] w2;
    apply_reset();
    out_ready = 1'b0;
    w1 = 32'hA4A3A2A1;
    w2 = 32'hA8A7A6A5;
    for (int i = 0; i < 8; i++) begin
      drive_byte(8'(8'hA1 + i), 1'b0);
      if (i >= 3) begin
        n_checks++;
        if ({l_out_valid, l_out_word, l_out_be} !== {1'b1, w1, 4'hF}) begin
          n_fail++;
          $display("FAIL hold_word[%0d]: valid=%b word=%h be=%h, want 1 %h f",
                   i, l_out_valid, l_out_word, l_out_be, w1);
        end
      end
    end
    n_checks++;
    if (l_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_ready: in_ready=%b after 8 stalled bytes, want 0", l_in_ready);
    end
    step();
    n_checks++;
    if ({l_in_ready, l_out_word} !== {1'b0, w1}) begin
      n_fail++;
      $display("FAIL pend_hold: in_ready=%b word=%h, want 0 %h", l_in_ready, l_out_word, w1);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_in_ready, l_words_sent} !== {1'b1, w2, 4'hF, 1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL second_word: valid=%b word=%h be=%h rdy=%b ws=%0d, want 1 %h f 1 1",
               l_out_valid, l_out_word, l_out_be, l_in_ready, l_words_sent, w2);
    end
    step();
    n_checks++;
    if ({l_out_valid, l_words_sent} !== {1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b ws=%0d, want 0 2", l_out_valid, l_words_sent);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_byte(8'(8'h50 + i), 1'b0);
    // a full word is held in the output and two bytes are in the accumulator
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_out_last, l_words_sent, l_in_ready} !==
        {1'b0, 32'h0, 4'h0, 1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b word=%h be=%h last=%b ws=%0d rdy=%b, want 0/0/0/0/0/1",
               l_out_valid, l_out_word, l_out_be, l_out_last, l_words_sent, l_in_ready);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) drive_byte(8'(8'hC1 + i), 1'b0);
    n_checks++;
    if (l_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_partial: out_valid=%b after 3 new bytes, want 0", l_out_valid);
    end
    drive_byte(8'hC4, 1'b0);
    n_checks++;
    if ({l_out_valid, l_out_word, l_out_be, l_out_last} !== {1'b1, 32'hC4C3C2C1, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_word: valid=%b word=%h be=%h last=%b, want 1 c4c3c2c1 f 0",
               l_out_valid, l_out_word, l_out_be, l_out_last);
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0]  cur[$];
    logic [31:0] exp_word_q[$];
    logic [31:0] exp_mword_q[$];
    logic [3:0]  exp_be_q[$];
    logic        exp_last_q[$];
    int          sent;
    int          cycles;
    int          hs;
    logic        took;
    logic        stalled;
    logic [36:0] held;
    logic [31:0] w;
    logic [31:0] mw;
    logic [68:0] exp_all;

    apply_reset();
    sent    = 0;
    cycles  = 0;
    hs      = 0;
    stalled = 1'b0;
    held    = '0;
    in_valid  = 1'b1;
    in_byte   = 8'($urandom);
    in_last   = 1'b0;
    out_ready = 1'b1;

    while (!(sent == N_RAND && exp_word_q.size() == 0) && cycles < BUDGET) begin
      // output stays put while stalled
      if (stalled) begin
        n_checks++;
        if ({l_out_valid, l_out_word, l_out_be} !== held) begin
          n_fail++;
          $display("FAIL rand_stable: cycle %0d got %h want %h", cycles,
                   {l_out_valid, l_out_word, l_out_be}, held);
        end
      end
      // output handshake on the coming edge
      if (l_out_valid && out_ready) begin
        hs++;
        n_checks++;
        if (exp_word_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra_word: got %h with empty scoreboard", l_out_word);
        end else begin
          exp_all = {exp_word_q.pop_front(), exp_be_q.pop_front(),
                     exp_last_q.pop_front(), exp_mword_q.pop_front()};
          if ({l_out_word, l_out_be, l_out_last, m_out_word} !== exp_all) begin
            n_fail++;
            $display("FAIL rand_word %0d: got w=%h be=%h last=%b mw=%h want w=%h be=%h last=%b mw=%h",
                     hs, l_out_word, l_out_be, l_out_last, m_out_word,
                     exp_all[68:37], exp_all[36:33], exp_all[32], exp_all[31:0]);
          end
        end
      end
      stalled = l_out_valid && !out_ready;
      held    = {l_out_valid, l_out_word, l_out_be};
      // input handshake on the coming edge: reference packing model
      took = in_valid && l_in_ready;
      if (took) begin
        sent++;
        cur.push_back(in_byte);
        if (cur.size() == 4 || in_last) begin
          w  = 32'h0;
          mw = 32'h0;
          for (int i = 0; i < cur.size(); i++) begin
            w  = w  | (32'(cur[i]) << (8 * i));
            mw = mw | (32'(cur[i]) << (8 * (3 - i)));
          end
          exp_word_q.push_back(w);
          exp_mword_q.push_back(mw);
          exp_be_q.push_back(4'((1 << cur.size()) - 1));
          exp_last_q.push_back(in_last);
          cur.delete();
        end
      end
      step();
      cycles++;
      // a byte that was not taken stays offered unchanged
      if (!(in_valid && !took)) begin
        if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_byte  = 8'($urandom);
          in_last  = (sent == N_RAND - 1) || ($urandom_range(0, 9) == 0);
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      out_ready = (sent == N_RAND) ? 1'b1 : ($urandom_range(0, 99) < 65);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    n_checks++;
    if (cycles >= BUDGET) begin
      n_fail++;
      $display("FAIL rand_timeout: %0d cycles, sent %0d of %0d, %0d words outstanding",
               cycles, sent, N_RAND, exp_word_q.size());
    end
    n_checks++;
    if (l_words_sent !== 16'(hs)) begin
      n_fail++;
      $display("FAIL rand_words_sent: got %0d want %0d", l_words_sent, 16'(hs));
    end
    n_checks++;
    if (m_words_sent !== 16'(hs)) begin
      n_fail++;
      $display("FAIL rand_words_sent_msb: got %0d want %0d", m_words_sent, 16'(hs));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_partial_last();
    test_back_pressure();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
